// File: rtl/simon_param_core_if.sv
// Host-side bus of simon_param_core.
//   data_in    : load digit (D bits), host -> core
//   data_rdy   : command, 00 idle / 01 key digit / 10 plaintext digit / 11 start
//   debug_port : 1 selects the round-key digit onto data_out
//   data_out   : ciphertext digit (or key digit in debug), core -> host
//   valid      : data_out carries a ciphertext digit this cycle
//   busy       : engine is running rounds or unloading
// master = host side, slave = core side.
interface simon_param_core_if #(
   parameter int unsigned D = 1
);
   logic [D-1:0] data_in;
   logic [1:0]   data_rdy;
   logic         debug_port;
   logic [D-1:0] data_out;
   logic         valid;
   logic         busy;

   modport master (
      output data_in, data_rdy, debug_port,
      input  data_out, valid, busy
   );

   modport slave (
      input  data_in, data_rdy, debug_port,
      output data_out, valid, busy
   );
endinterface

// File: rtl/simon_param_core.sv
// Parametrised Simon block-cipher engine, one round per cycle on full-width registers.
// Key and plaintext are loaded MSB-first through a D-bit digit-serial port; the ciphertext
// is unloaded the same way. The master key is kept so several blocks can share one key load.
//   clk   : clock, rising edge
//   reset : synchronous, active-high; clears all state
//   bus   : simon_param_core_if slave modport (data_in, data_rdy, debug_port,
//           data_out, valid, busy)
module simon_param_core #(
   parameter int unsigned N = 64,
   parameter int unsigned M = 2,
   parameter int unsigned T = 68,
   parameter logic [61:0] Z = 62'b10101111011100000011010010011000101000010001111110010110110011,
   parameter int unsigned D = 1
) (
   input logic                clk,
   input logic                reset,
   simon_param_core_if.slave  bus
);

   localparam int unsigned KW  = M * N;
   localparam int unsigned BW  = 2 * N;
   localparam int unsigned ND  = BW / D;
   localparam int unsigned RcW = (T > 1) ? $clog2(T) : 1;
   localparam int unsigned OcW = (ND > 1) ? $clog2(ND) : 1;

   localparam logic [RcW-1:0] RcLast = RcW'(T - 1);
   localparam logic [OcW-1:0] OcLast = OcW'(ND - 1);
   localparam logic [N-1:0]   KConst = N'(3);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StOut  = 2'd2;

   // Illegal configurations are flagged at elaboration.
   if ((D == 0) || ((N % D) != 0) || (M < 2) || (M > 4) || (T == 0)) begin : g_param_err
      $error("simon_param_core: illegal parameters (D must divide N, M in 2..4, T > 0)");
   end

   function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int unsigned s);
      return (v << s) | (v >> (N - s));
   endfunction

   function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int unsigned s);
      return (v >> s) | (v << (N - s));
   endfunction

   logic [1:0]     state_q, state_d;
   logic [KW-1:0]  mkey_q, mkey_d;
   logic [KW-1:0]  wkey_q, wkey_d;   // {k(M-1), ..., k1, k0}, k0 in the low word
   logic [N-1:0]   x_q, x_d;
   logic [N-1:0]   y_q, y_d;
   logic [BW-1:0]  oreg_q, oreg_d;
   logic [61:0]    zreg_q, zreg_d;
   logic [RcW-1:0] rc_q, rc_d;
   logic [OcW-1:0] oc_q, oc_d;

   logic [N-1:0]   k0;
   logic [N-1:0]   x_rnd;
   logic [N-1:0]   ktmp;
   logic [N-1:0]   knew;
   logic [BW-1:0]  xy;

   // Round function and key expansion.
   always_comb begin
      k0    = wkey_q[N-1:0];
      x_rnd = y_q ^ (rol(x_q, 1) & rol(x_q, 8)) ^ rol(x_q, 2) ^ k0;
      ktmp  = ror(wkey_q[KW-1 -: N], 3);
      if (M == 4) begin
         ktmp = ktmp ^ wkey_q[2*N-1 : N];
      end
      ktmp = ktmp ^ ror(ktmp, 1);
      // ~k0 ^ 3 is the Simon round constant c = 2^N - 4 folded into k0.
      knew = ~k0 ^ ktmp ^ {{(N-1){1'b0}}, zreg_q[61]} ^ KConst;
   end

   always_comb begin
      state_d = state_q;
      mkey_d  = mkey_q;
      wkey_d  = wkey_q;
      x_d     = x_q;
      y_d     = y_q;
      oreg_d  = oreg_q;
      zreg_d  = zreg_q;
      rc_d    = rc_q;
      oc_d    = oc_q;
      xy      = {x_q, y_q};

      unique case (state_q)
         StIdle: begin
            // Host commands are honoured only here, so busy locks them all out.
            case (bus.data_rdy)
               2'b01: mkey_d = {mkey_q[KW-D-1:0], bus.data_in};
               2'b10: {x_d, y_d} = {xy[BW-D-1:0], bus.data_in};
               2'b11: begin
                  state_d = StRun;
                  wkey_d  = mkey_q;
                  zreg_d  = Z;
                  rc_d    = '0;
               end
               default: ;
            endcase
         end
         StRun: begin
            x_d    = x_rnd;
            y_d    = x_q;
            wkey_d = {knew, wkey_q[KW-1:N]};
            zreg_d = {zreg_q[60:0], zreg_q[61]};
            rc_d   = rc_q + 1'b1;
            if (rc_q == RcLast) begin
               state_d = StOut;
               oreg_d  = {x_rnd, x_q};
               oc_d    = '0;
            end
         end
         StOut: begin
            // Zeros shift in, so oreg is empty (data_out = 0) once unloading ends.
            oreg_d = {oreg_q[BW-D-1:0], {D{1'b0}}};
            oc_d   = oc_q + 1'b1;
            if (oc_q == OcLast) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         mkey_q  <= '0;
         wkey_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         oreg_q  <= '0;
         zreg_q  <= Z;
         rc_q    <= '0;
         oc_q    <= '0;
      end else begin
         state_q <= state_d;
         mkey_q  <= mkey_d;
         wkey_q  <= wkey_d;
         x_q     <= x_d;
         y_q     <= y_d;
         oreg_q  <= oreg_d;
         zreg_q  <= zreg_d;
         rc_q    <= rc_d;
         oc_q    <= oc_d;
      end
   end

   // Debug mux is the only combinational path to data_out.
   assign bus.data_out = bus.debug_port ? wkey_q[N-1 -: D] : oreg_q[BW-1 -: D];
   assign bus.valid    = (state_q == StOut);
   assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_simon_param_core.sv
// Scoreboard bench for simon_param_core: a Simon128/128 instance (D=1) and a
// Simon32/64 instance (D=4). Stimulus pushes expected digits and first-valid cycles
// into queues; per-instance monitors pop and compare whenever valid is high.
module tb_simon_param_core;

   localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
   localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;

   localparam logic [127:0] KeyA = 128'h0f0e0d0c0b0a0908_0706050403020100;
   localparam logic [127:0] PtA  = 128'h6373656420737265_6c6c657661727420;
   localparam logic [127:0] CtA  = 128'h49681b1e1e54fe3f_65aa832af84e0bbc;
   localparam logic [63:0]  KeyB = 64'h1918_1110_0908_0100;
   localparam logic [31:0]  PtB  = 32'h6565_6877;
   localparam logic [31:0]  CtB  = 32'hc69b_e9bb;

   logic clk = 1'b0;
   logic rst_a, rst_b;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   simon_param_core_if #(.D(1)) ifa ();
   simon_param_core_if #(.D(4)) ifb ();

   simon_param_core dut_a (
      .clk   (clk),
      .reset (rst_a),
      .bus   (ifa)
   );

   simon_param_core #(
      .N (16),
      .M (4),
      .T (32),
      .Z (Z0),
      .D (4)
   ) dut_b (
      .clk   (clk),
      .reset (rst_b),
      .bus   (ifb)
   );

   logic [3:0] qa_dig[$];
   int         qa_lat[$];
   logic [3:0] qb_dig[$];
   int         qb_lat[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Independent Simon128/128 reference, used for the all-zero key/plaintext case.
   function automatic logic [63:0] rl64(input logic [63:0] v, input int s);
      return (v << s) | (v >> (64 - s));
   endfunction

   function automatic logic [127:0] simon128_ref(input logic [127:0] key,
                                                 input logic [127:0] pt);
      logic [63:0] k [0:67];
      logic [63:0] x, y, tmp;
      logic [61:0] z;
      z    = Z2;
      k[0] = key[63:0];
      k[1] = key[127:64];
      for (int i = 0; i < 66; i++) begin
         tmp = rl64(k[i+1], 61);
         tmp = tmp ^ rl64(tmp, 63);
         k[i+2] = ~k[i] ^ tmp ^ {63'd0, z[61 - (i % 62)]} ^ 64'd3;
      end
      x = pt[127:64];
      y = pt[63:0];
      for (int i = 0; i < 68; i++) begin
         tmp = x;
         x   = y ^ (rl64(x, 1) & rl64(x, 8)) ^ rl64(x, 2) ^ k[i];
         y   = tmp;
      end
      return {x, y};
   endfunction

   task automatic load_a(input logic [1:0] cmd, input logic [127:0] v);
      for (int i = 127; i >= 0; i--) begin
         ifa.data_rdy = cmd;
         ifa.data_in  = v[i];
         tick();
      end
      ifa.data_rdy = 2'b00;
      ifa.data_in  = 1'b0;
   endtask

   task automatic load_b(input logic [1:0] cmd, input logic [63:0] v, input int ndig);
      for (int i = ndig - 1; i >= 0; i--) begin
         ifb.data_rdy = cmd;
         ifb.data_in  = v[i*4 +: 4];
         tick();
      end
      ifb.data_rdy = 2'b00;
      ifb.data_in  = 4'h0;
   endtask

   task automatic start_a(input logic [127:0] ct);
      for (int i = 127; i >= 0; i--) qa_dig.push_back({3'b000, ct[i]});
      qa_lat.push_back(cyc + 1 + 68);
      ifa.data_rdy = 2'b11;
      tick();
      ifa.data_rdy = 2'b00;
   endtask

   task automatic start_b(input logic [31:0] ct);
      for (int i = 7; i >= 0; i--) qb_dig.push_back(ct[i*4 +: 4]);
      qb_lat.push_back(cyc + 1 + 32);
      ifb.data_rdy = 2'b11;
      tick();
      ifb.data_rdy = 2'b00;
   endtask

   task automatic wait_idle(input bit sel_b, input string name);
      int n = 0;
      while ((sel_b ? ifb.busy : ifa.busy) && n < 1000) begin
         tick();
         n++;
      end
      chk(name, sel_b ? ifb.busy : ifa.busy, 1'b0);
      tick();
      tick();
   endtask

   // Monitor for the 128/128 instance.
   initial begin
      bit         pv = 1'b0;
      int         run = 0;
      logic [3:0] e;
      forever begin
         @(negedge clk);
         if (ifa.valid) begin
            chk("a_busy_with_valid", ifa.busy, 1'b1);
            if (!pv) begin
               run = 0;
               if (qa_lat.size() == 0) chk("a_unexpected_valid", 1'b1, 1'b0);
               else chk("a_first_valid_cycle", cyc, qa_lat.pop_front());
            end
            run++;
            if (qa_dig.size() == 0) chk("a_extra_digit", 1'b1, 1'b0);
            else begin
               e = qa_dig.pop_front();
               if (!ifa.debug_port) chk("a_ct_digit", ifa.data_out, e[0]);
            end
         end else if (pv) begin
            chk("a_valid_run_len", run, 128);
            chk("a_busy_falls_with_valid", ifa.busy, 1'b0);
         end
         pv = ifa.valid;
      end
   end

   // Monitor for the 32/64 instance.
   initial begin
      bit         pv = 1'b0;
      int         run = 0;
      logic [3:0] e;
      forever begin
         @(negedge clk);
         if (ifb.valid) begin
            chk("b_busy_with_valid", ifb.busy, 1'b1);
            if (!pv) begin
               run = 0;
               if (qb_lat.size() == 0) chk("b_unexpected_valid", 1'b1, 1'b0);
               else chk("b_first_valid_cycle", cyc, qb_lat.pop_front());
            end
            run++;
            if (qb_dig.size() == 0) chk("b_extra_digit", 1'b1, 1'b0);
            else begin
               e = qb_dig.pop_front();
               if (!ifb.debug_port) chk("b_ct_digit", ifb.data_out, e);
            end
         end else if (pv) begin
            chk("b_valid_run_len", run, 8);
            chk("b_busy_falls_with_valid", ifb.busy, 1'b0);
         end
         pv = ifb.valid;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_a = 1'b1;
      rst_b = 1'b1;
      ifa.data_in = '0; ifa.data_rdy = 2'b00; ifa.debug_port = 1'b0;
      ifb.data_in = '0; ifb.data_rdy = 2'b00; ifb.debug_port = 1'b0;
      tick();
      tick();
      rst_a = 1'b0;
      rst_b = 1'b0;
      @(negedge clk);
      chk("a_reset_valid", ifa.valid, 1'b0);
      chk("a_reset_busy", ifa.busy, 1'b0);
      chk("a_reset_data_out", ifa.data_out, 1'b0);
      chk("b_reset_valid", ifb.valid, 1'b0);
      chk("b_reset_busy", ifb.busy, 1'b0);
      chk("b_reset_data_out", ifb.data_out, 4'h0);
      tick();

      // Simon128/128 vector, debug on the first RUN cycle.
      load_a(2'b01, KeyA);
      load_a(2'b10, PtA);
      start_a(CtA);
      ifa.debug_port = 1'b1;
      @(negedge clk);
      chk("a_busy_after_start", ifa.busy, 1'b1);
      chk("a_debug_k0_msb", ifa.data_out, 1'b0);
      chk("a_debug_valid_low", ifa.valid, 1'b0);
      tick();
      ifa.debug_port = 1'b0;
      wait_idle(1'b0, "a_run1_idle");

      // Simon32/64 vector, debug shows k0..k3 top nibbles across RUN cycles 1..4.
      load_b(2'b01, KeyB, 16);
      load_b(2'b10, {32'd0, PtB}, 8);
      start_b(CtB);
      ifb.debug_port = 1'b1;
      @(negedge clk);
      chk("b_debug_k0", ifb.data_out, 4'h0);
      tick();
      @(negedge clk);
      chk("b_debug_k1", ifb.data_out, 4'h0);
      tick();
      @(negedge clk);
      chk("b_debug_k2", ifb.data_out, 4'h1);
      tick();
      @(negedge clk);
      chk("b_debug_k3", ifb.data_out, 4'h1);
      tick();
      ifb.debug_port = 1'b0;
      n = 0;
      while (!ifb.valid && n < 100) begin
         tick();
         n++;
      end
      chk("b_valid_reached", ifb.valid, 1'b1);
      ifb.debug_port = 1'b1;
      @(negedge clk);
      chk("b_valid_with_debug", ifb.valid, 1'b1);
      tick();
      ifb.debug_port = 1'b0;
      @(negedge clk);
      chk("b_valid_after_debug", ifb.valid, 1'b1);
      wait_idle(1'b1, "b_run_idle");

      // Busy lockout: key, plaintext and start commands during RUN and OUT.
      load_a(2'b10, PtA);
      start_a(CtA);
      for (int i = 0; i < 168; i++) begin
         ifa.data_rdy = (i % 3 == 0) ? 2'b10 : ((i % 3 == 1) ? 2'b11 : 2'b01);
         ifa.data_in  = 1'($urandom_range(0, 1));
         tick();
      end
      ifa.data_rdy = 2'b00;
      ifa.data_in  = 1'b0;
      wait_idle(1'b0, "a_lockout_idle");

      // Key reuse: plaintext only.
      load_a(2'b10, PtA);
      start_a(CtA);
      wait_idle(1'b0, "a_reuse_idle");

      // Mid-run reset, then an unloaded start encrypts zero with the zero key.
      load_a(2'b10, PtA);
      start_a(CtA);
      repeat (9) tick();
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
      qa_dig.delete();
      qa_lat.delete();
      @(negedge clk);
      chk("a_midreset_valid", ifa.valid, 1'b0);
      chk("a_midreset_busy", ifa.busy, 1'b0);
      chk("a_midreset_data_out", ifa.data_out, 1'b0);
      tick();
      start_a(simon128_ref(128'd0, 128'd0));
      wait_idle(1'b0, "a_zero_key_idle");

      chk("a_queue_drained", qa_dig.size(), 0);
      chk("b_queue_drained", qb_dig.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
